// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame reader: display/source geometry,
// RGB565 field positions, the 4:4:4 colour type and the overlay box record.
package vga_pkg;

   localparam int DISP_WIDTH  = 640;
   localparam int DISP_HEIGHT = 480;
   localparam int SRC_WIDTH   = 320;
   localparam int SRC_HEIGHT  = 240;

   // Top four bits of each RGB565 field feed the 4:4:4 DAC.
   localparam int R_MSB = 15;
   localparam int R_LSB = 12;
   localparam int G_MSB = 10;
   localparam int G_LSB = 7;
   localparam int B_MSB = 4;
   localparam int B_LSB = 1;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam logic [11:0] BOX_COLOR_DEF = 12'hF00;

   typedef struct packed {
      logic        en;
      logic [11:0] x0;
      logic [11:0] y0;
      logic [11:0] x1;
      logic [11:0] y1;
   } box_t;

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with a per-bit reset value, used to keep syncs,
// video_on and box_hit aligned with the frame buffer read latency.
module vga_pipe_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] stage_q [DEPTH];

   always_comb begin
      stage_d[0] = d_in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the 320x240 RGB565 camera buffer with 2x pixel replication, overlays a
// frame-synchronous bounding box and drives 4:4:4 VGA with latency-matched syncs.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int          SRC_W     = SRC_WIDTH,
   parameter int          SRC_H     = SRC_HEIGHT,
   parameter int          DISP_H    = DISP_HEIGHT,
   parameter int          ADDR_W    = 17,
   parameter int          PIX_W     = 16,
   parameter int          RD_LAT    = 2,
   parameter logic [11:0] BOX_COLOR = BOX_COLOR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              video_on_in,
   input  logic [11:0]       pixel_x,
   input  logic [11:0]       pixel_y,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_rd_addr,
   input  logic [PIX_W-1:0]  fb_rd_data,
   input  logic              box_valid,
   output logic              box_ready,
   input  logic              box_en,
   input  logic [11:0]       box_x0,
   input  logic [11:0]       box_y0,
   input  logic [11:0]       box_x1,
   input  logic [11:0]       box_y1,
   output logic              frame_start,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              hsync_out,
   output logic              vsync_out
);

   localparam int PIPE_D = RD_LAT + 1;

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              rd_en_d, rd_en_q;
   box_t              pend_d, pend_q, act_d, act_q;
   logic              pend_full_d, pend_full_q;
   logic              frame_start_d, frame_start_q;
   rgb444_t           rgb_d, rgb_q;
   logic              hs_d, hs_q, vs_d, vs_q;

   logic              frame_edge, in_src, box_hit;
   logic [ADDR_W-1:0] row_addr, col_addr, addr_calc;
   logic [3:0]        pipe_out;
   logic              hs_dly, vs_dly, von_dly, hit_dly;
   logic              unused_pix_bits;

   assign frame_edge = (pixel_x == 12'd0) && (pixel_y == 12'(DISP_H));
   assign in_src     = (pixel_x < 12'(DISP_WIDTH)) && (pixel_y[11:1] < 11'(SRC_H));

   // Stage A: replicated-pixel address, held while blanking.
   always_comb begin
      row_addr  = ADDR_W'(pixel_y[11:1]);
      col_addr  = ADDR_W'(pixel_x[11:1]);
      addr_calc = row_addr * ADDR_W'(SRC_W) + col_addr;
      rd_en_d   = video_on_in;
      addr_d    = (video_on_in && in_src) ? addr_calc : addr_q;
   end

   // Capture needs an empty slot and commit needs a full one, so they never collide.
   always_comb begin
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      act_d         = act_q;
      frame_start_d = frame_edge;
      if (box_valid && box_ready) begin
         pend_d      = '{en: box_en, x0: box_x0, y0: box_y0, x1: box_x1, y1: box_y1};
         pend_full_d = 1'b1;
      end else if (frame_edge && pend_full_q) begin
         act_d       = pend_q;
         pend_full_d = 1'b0;
      end
   end

   // 13-bit compares so x0+1 / x1-1 cannot wrap into a false hit.
   always_comb begin
      logic [12:0] bx, by, x0e, y0e, x1e, y1e;
      logic        in_x, in_y, edge_x, edge_y;
      bx      = {1'b0, pixel_x};
      by      = {1'b0, pixel_y};
      x0e     = {1'b0, act_q.x0};
      y0e     = {1'b0, act_q.y0};
      x1e     = {1'b0, act_q.x1};
      y1e     = {1'b0, act_q.y1};
      in_x    = (bx >= x0e) && (bx <= x1e);
      in_y    = (by >= y0e) && (by <= y1e);
      edge_x  = (bx <= x0e + 13'd1) || (bx + 13'd1 >= x1e);
      edge_y  = (by <= y0e + 13'd1) || (by + 13'd1 >= y1e);
      box_hit = act_q.en && (x0e <= x1e) && (y0e <= y1e) && in_x && in_y &&
                (edge_x || edge_y);
   end

   vga_pipe_delay #(
      .WIDTH   (4),
      .DEPTH   (PIPE_D),
      .RST_VAL (4'b1100)
   ) u_side_dly (
      .clk   (clk),
      .rst   (rst),
      .d_in  ({hsync_in, vsync_in, video_on_in, box_hit}),
      .d_out (pipe_out)
   );

   assign {hs_dly, vs_dly, von_dly, hit_dly} = pipe_out;

   // Low RGB565 bits are dropped by the 4:4:4 conversion.
   assign unused_pix_bits = ^{fb_rd_data[11], fb_rd_data[6:5], fb_rd_data[0]};

   always_comb begin
      rgb_d = '0;
      if (von_dly) begin
         if (hit_dly) rgb_d = BOX_COLOR;
         else         rgb_d = {fb_rd_data[R_MSB:R_LSB], fb_rd_data[G_MSB:G_LSB],
                               fb_rd_data[B_MSB:B_LSB]};
      end
      hs_d = hs_dly;
      vs_d = vs_dly;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         rd_en_q       <= 1'b0;
         pend_q        <= '0;
         act_q         <= '0;
         pend_full_q   <= 1'b0;
         frame_start_q <= 1'b0;
         rgb_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
      end else begin
         addr_q        <= addr_d;
         rd_en_q       <= rd_en_d;
         pend_q        <= pend_d;
         act_q         <= act_d;
         pend_full_q   <= pend_full_d;
         frame_start_q <= frame_start_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
      end
   end

   assign box_ready   = !rst && !pend_full_q;
   assign fb_rd_en    = rd_en_q;
   assign fb_rd_addr  = addr_q;
   assign frame_start = frame_start_q;
   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign hsync_out   = hs_q;
   assign vsync_out   = vs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: address mapping, latency, blanking,
// box handshake / frame-boundary commit, inverted and disabled boxes, reset.
module tb_vga_frame_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        hs_in, vs_in, von_in;
   logic [11:0] pixel_x, pixel_y;
   logic        fb_rd_en;
   logic [16:0] fb_rd_addr;
   logic [15:0] fb_rd_data;
   logic        box_valid, box_ready, box_en;
   logic [11:0] box_x0, box_y0, box_x1, box_y1;
   logic        frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        hsync_out, vsync_out;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] mem [0:76799];
   logic [15:0] d1, d2;
   logic [3:0]  hs_hist;

   always #5 clk = ~clk;

   // Frame buffer model with two cycles of read latency.
   always @(posedge clk) begin
      d1 <= mem[fb_rd_addr];
      d2 <= d1;
   end
   assign fb_rd_data = d2;

   vga_frame_reader dut (
      .clk         (clk),
      .rst         (rst),
      .hsync_in    (hs_in),
      .vsync_in    (vs_in),
      .video_on_in (von_in),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .fb_rd_en    (fb_rd_en),
      .fb_rd_addr  (fb_rd_addr),
      .fb_rd_data  (fb_rd_data),
      .box_valid   (box_valid),
      .box_ready   (box_ready),
      .box_en      (box_en),
      .box_x0      (box_x0),
      .box_y0      (box_y0),
      .box_x1      (box_x1),
      .box_y1      (box_y1),
      .frame_start (frame_start),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int x, input int y, input logic von);
      pixel_x = 12'(x);
      pixel_y = 12'(y);
      von_in  = von;
   endtask

   // Pixel for one cycle, then blanking fillers; rgb checked L=4 cycles later.
   task automatic pix_check(input string tag, input int x, input int y, input logic [11:0] exp);
      drive(x, y, 1'b1);
      tick;
      drive(700, y, 1'b0);
      tick;
      tick;
      tick;
      chk(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
   endtask

   task automatic offer_box(input int x0, input int y0, input int x1, input int y1, input logic en);
      box_x0    = 12'(x0);
      box_y0    = 12'(y0);
      box_x1    = 12'(x1);
      box_y1    = 12'(y1);
      box_en    = en;
      box_valid = 1'b1;
      drive(700, 30, 1'b0);
      chk("ready_before_offer", {31'd0, box_ready}, 32'd1);
      tick;
      box_valid = 1'b0;
      chk("ready_after_offer", {31'd0, box_ready}, 32'd0);
   endtask

   task automatic frame_boundary;
      drive(0, 480, 1'b0);
      tick;
      chk("frame_start_pulse", {31'd0, frame_start}, 32'd1);
      chk("ready_after_boundary", {31'd0, box_ready}, 32'd1);
      drive(1, 480, 1'b0);
      tick;
      chk("frame_start_single", {31'd0, frame_start}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 76800; i++) mem[i] = 16'h0000;
      mem[1605]  = 16'hFFFF;   // pixel (10,10)
      mem[1606]  = 16'h07E0;   // pixel (12,10)
      mem[1607]  = 16'hA5C3;   // pixel (14,10)
      mem[1610]  = 16'hFFFF;   // pixel (20,10)
      mem[12850] = 16'h07E0;   // pixel (100,80)
      mem[12849] = 16'hFFFF;   // pixel (99,80)
      mem[12851] = 16'h07E0;   // pixel (102,80)
      mem[16075] = 16'hA5C3;   // pixel (150,100)
      mem[16100] = 16'hFFFF;   // pixel (200,100)
      mem[8395]  = 16'hFFFF;   // pixel (150,52)
      mem[24075] = 16'hA5C3;   // pixel (150,151)
      mem[8075]  = 16'h07E0;   // pixel (150,50)

      rst = 1'b1;
      hs_in = 1'b1;
      vs_in = 1'b1;
      box_valid = 1'b0;
      box_en = 1'b0;
      box_x0 = '0; box_y0 = '0; box_x1 = '0; box_y1 = '0;
      drive(0, 0, 1'b0);
      tick;
      tick;
      chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
      chk("rst_rd_en", {31'd0, fb_rd_en}, 32'd0);
      chk("rst_addr", {15'd0, fb_rd_addr}, 32'd0);
      chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
      chk("rst_syncs", {30'd0, hsync_out, vsync_out}, 32'd3);
      chk("rst_ready", {31'd0, box_ready}, 32'd0);
      rst = 1'b0;
      tick;
      chk("post_rst_ready", {31'd0, box_ready}, 32'd1);

      // Address mapping.
      drive(0, 0, 1'b1);
      tick;
      chk("rd_en_0_0", {31'd0, fb_rd_en}, 32'd1);
      chk("addr_0_0", {15'd0, fb_rd_addr}, 32'd0);
      drive(639, 479, 1'b1);
      tick;
      chk("addr_639_479", {15'd0, fb_rd_addr}, 32'd76799);
      drive(2, 0, 1'b1);
      tick;
      chk("addr_2_0", {15'd0, fb_rd_addr}, 32'd1);
      drive(3, 0, 1'b1);
      tick;
      chk("addr_3_0", {15'd0, fb_rd_addr}, 32'd1);

      // Latency and RGB565 field extraction.
      pix_check("rgb_white", 10, 10, 12'hFFF);
      pix_check("rgb_green", 12, 10, 12'h0F0);
      pix_check("rgb_mixed", 14, 10, 12'hAB1);

      // Blanking: enable drops, address holds, rgb forced to zero.
      drive(20, 10, 1'b1);
      tick;
      drive(700, 10, 1'b0);
      tick;
      chk("blank_rd_en", {31'd0, fb_rd_en}, 32'd0);
      chk("blank_addr_hold", {15'd0, fb_rd_addr}, 32'd1610);
      tick;
      tick;
      chk("active_before_blank", {20'd0, vga_r, vga_g, vga_b}, 32'h0FFF);
      tick;
      chk("blank_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);

      // hsync_out follows hsync_in four cycles later over one full line.
      hs_hist = 4'hF;
      for (int x = 0; x < 800; x++) begin
         hs_in = !(x >= 656 && x < 752);
         drive(x, 20, x < 640);
         hs_hist = {hs_hist[2:0], hs_in};
         tick;
         chk("hsync_delay", {31'd0, hsync_out}, {31'd0, hs_hist[3]});
      end
      hs_in = 1'b1;

      // Box offered mid-frame: not visible until after the boundary.
      offer_box(100, 50, 200, 150, 1'b1);
      pix_check("no_tear_100_80", 100, 80, 12'h0F0);
      frame_boundary();
      pix_check("box_corner_100_80", 100, 80, 12'hF00);
      pix_check("box_right_200_100", 200, 100, 12'hF00);
      pix_check("box_right_199_100", 199, 100, 12'hF00);
      pix_check("box_inside_150_100", 150, 100, 12'hAB1);
      pix_check("box_left_out_99_80", 99, 80, 12'hFFF);
      pix_check("box_past_edge_102_80", 102, 80, 12'h0F0);
      pix_check("box_top2_150_51", 150, 51, 12'hF00);
      pix_check("box_top_in_150_52", 150, 52, 12'hFFF);
      pix_check("box_below_150_151", 150, 151, 12'hAB1);

      // Inverted box is never drawn.
      offer_box(200, 50, 100, 150, 1'b1);
      frame_boundary();
      pix_check("inv_100_80", 100, 80, 12'h0F0);
      pix_check("inv_200_100", 200, 100, 12'hFFF);
      pix_check("inv_150_50", 150, 50, 12'h0F0);

      // Restore a box, then remove it with box_en=0.
      offer_box(100, 50, 200, 150, 1'b1);
      frame_boundary();
      pix_check("restore_100_80", 100, 80, 12'hF00);
      offer_box(100, 50, 200, 150, 1'b0);
      pix_check("remove_pending_100_80", 100, 80, 12'hF00);
      frame_boundary();
      pix_check("removed_100_80", 100, 80, 12'h0F0);
      pix_check("removed_200_100", 200, 100, 12'hFFF);

      // Reset mid-line with an active box.
      offer_box(100, 50, 200, 150, 1'b1);
      frame_boundary();
      hs_in = 1'b0;
      vs_in = 1'b0;
      drive(100, 80, 1'b1);
      tick;
      tick;
      tick;
      tick;
      chk("pre_rst_box", {20'd0, vga_r, vga_g, vga_b}, 32'h0F00);
      chk("pre_rst_syncs", {30'd0, hsync_out, vsync_out}, 32'd0);
      rst = 1'b1;
      tick;
      chk("midrst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
      chk("midrst_syncs", {30'd0, hsync_out, vsync_out}, 32'd3);
      chk("midrst_ready", {31'd0, box_ready}, 32'd0);
      chk("midrst_rd_en", {31'd0, fb_rd_en}, 32'd0);
      hs_in = 1'b1;
      vs_in = 1'b1;
      rst = 1'b0;
      tick;
      chk("postrst_ready", {31'd0, box_ready}, 32'd1);
      pix_check("postrst_no_box", 100, 80, 12'h0F0);
      frame_boundary();
      pix_check("postrst_next_frame", 100, 80, 12'h0F0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
